// File: rtl/rgb_fade_sequencer.sv
// RGB keyframe fade sequencer: ramps three 8-bit PWM duties by one LSB per fade
// tick toward the active keyframe, holds for a number of ticks, then advances.
module rgb_fade_sequencer #(
    parameter int PRESCALER  = 8,
    parameter int NUM_KEYS   = 4,
    parameter int HOLD_TICKS = 16,
    parameter int IDX_W      = $clog2(NUM_KEYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_index,
    input  logic [23:0]      cfg_rgb,
    output logic [7:0]       duty_r,
    output logic [7:0]       duty_g,
    output logic [7:0]       duty_b,
    output logic             duty_valid,
    output logic [IDX_W-1:0] key_index,
    output logic             busy
);

    localparam int CNT_W  = $clog2(PRESCALER + 1);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALER - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FADE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  prescale_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [IDX_W-1:0]  key_nxt;
    logic [7:0]        r_nxt;
    logic [7:0]        g_nxt;
    logic [7:0]        b_nxt;
    logic              duty_valid_nxt;

    logic [23:0] key_table [NUM_KEYS];
    logic [23:0] target;
    logic [31:0] cfg_index_ext;
    logic [31:0] key_index_ext;
    logic        tick;
    logic        at_target;

    assign cfg_ready     = 1'b1;
    assign busy          = (state != ST_IDLE);
    assign cfg_index_ext = 32'(cfg_index);
    assign key_index_ext = 32'(key_index);

    // Writes are matched against each legal entry, so an out-of-range index
    // simply never matches and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_table[i] <= 24'h000000;
            end
        end else if (cfg_valid) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (cfg_index_ext == 32'(i)) begin
                    key_table[i] <= cfg_rgb;
                end
            end
        end
    end

    always_comb begin
        target = 24'h000000;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_index_ext == 32'(i)) begin
                target = key_table[i];
            end
        end
    end

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] res;
        res = cur;
        if (cur < tgt) begin
            res = cur + 8'd1;
        end else if (cur > tgt) begin
            res = cur - 8'd1;
        end
        return res;
    endfunction

    assign tick      = (state != ST_IDLE) && (prescale_cnt == CNT_LAST);
    assign at_target = (duty_r == target[23:16]) &&
                       (duty_g == target[15:8])  &&
                       (duty_b == target[7:0]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = prescale_cnt;
        hold_nxt  = hold_cnt;
        key_nxt   = key_index;
        r_nxt     = duty_r;
        g_nxt     = duty_g;
        b_nxt     = duty_b;

        case (state)
            ST_IDLE: begin
                cnt_nxt  = '0;
                hold_nxt = '0;
                r_nxt    = 8'd0;
                g_nxt    = 8'd0;
                b_nxt    = 8'd0;
                if (enable) begin
                    state_nxt = ST_FADE;
                    key_nxt   = '0;
                end
            end
            ST_FADE: begin
                cnt_nxt = tick ? '0 : prescale_cnt + 1'b1;
                // Arrival is checked every clock so a retarget onto the current
                // duties ends the fade without waiting for a tick.
                if (at_target) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = HOLD_LOAD;
                end else if (tick) begin
                    r_nxt = step_toward(duty_r, target[23:16]);
                    g_nxt = step_toward(duty_g, target[15:8]);
                    b_nxt = step_toward(duty_b, target[7:0]);
                end
            end
            ST_HOLD: begin
                cnt_nxt = tick ? '0 : prescale_cnt + 1'b1;
                if (tick) begin
                    if (hold_cnt <= HOLD_ONE) begin
                        hold_nxt  = '0;
                        state_nxt = ST_FADE;
                        key_nxt   = (key_index == IDX_LAST) ? '0 : key_index + 1'b1;
                    end else begin
                        hold_nxt = hold_cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if ((state != ST_IDLE) && !enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            hold_nxt  = '0;
            key_nxt   = '0;
            r_nxt     = 8'd0;
            g_nxt     = 8'd0;
            b_nxt     = 8'd0;
        end

        duty_valid_nxt = ({r_nxt, g_nxt, b_nxt} != {duty_r, duty_g, duty_b});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            prescale_cnt <= '0;
            hold_cnt     <= '0;
            key_index    <= '0;
            duty_r       <= 8'd0;
            duty_g       <= 8'd0;
            duty_b       <= 8'd0;
            duty_valid   <= 1'b0;
        end else begin
            state        <= state_nxt;
            prescale_cnt <= cnt_nxt;
            hold_cnt     <= hold_nxt;
            key_index    <= key_nxt;
            duty_r       <= r_nxt;
            duty_g       <= g_nxt;
            duty_b       <= b_nxt;
            duty_valid   <= duty_valid_nxt;
        end
    end

endmodule
